// File: rtl/veda_pkg.sv
// veda_pkg: shared widths, memory mode encodings and the record types used by
// the veda command scheduler and its write buffer.
package veda_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic MODE_SCRIBBLE  = 1'b0;
  localparam logic MODE_INTERPRET = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // One buffered write.
  typedef struct packed {
    addr_t addr;
    data_t data;
  } wentry_t;

  // One stage of the read response pipeline.
  typedef struct packed {
    logic  valid;
    logic  fwd;
    data_t data;
  } rsp_stage_t;

  // Per-cycle issue choice, encoded as {head_valid, read_needs_memory}.
  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'b00,
    ISSUE_READ  = 2'b01,
    ISSUE_WRITE = 2'b10,
    ISSUE_BOTH  = 2'b11
  } issue_e;

endpackage

// File: rtl/veda_sched_if.sv
// veda_sched_if: request/response channels and the memory command bus of the
// veda scheduler. master = client plus memory side, slave = the scheduler.
interface veda_sched_if #(
  parameter int WBUF_DEPTH = 4
);
  import veda_pkg::*;

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic             wr_valid;
  logic             wr_ready;
  addr_t            wr_addr;
  data_t            wr_data;
  logic             rd_valid;
  logic             rd_ready;
  addr_t            rd_addr;
  logic             rsp_valid;
  data_t            rsp_data;
  logic [CNT_W-1:0] wbuf_count;
  logic             mem_mode;
  logic             mem_we;
  addr_t            mem_addr_a;
  addr_t            mem_addr_b;
  data_t            mem_data_in;
  data_t            mem_data_out;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_data_out,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, wbuf_count,
           mem_mode, mem_we, mem_addr_a, mem_addr_b, mem_data_in
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_data_out,
    output wr_ready, rd_ready, rsp_valid, rsp_data, wbuf_count,
           mem_mode, mem_we, mem_addr_a, mem_addr_b, mem_data_in
  );

endinterface

// File: rtl/veda_wbuf.sv
// veda_wbuf: circular write buffer with head/tail pointers and an associative
// search port returning the newest entry matching a given address.
// Callers only push when not full and only pop when not empty.
module veda_wbuf
  import veda_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  wentry_t          i_entry,
  input  logic             i_pop,
  output wentry_t          o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count,
  input  addr_t            i_search_addr,
  output logic             o_hit,
  output data_t            o_hit_data
);

  wentry_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Entry storage: written at the tail on every accepted push.
  // NOTE: the entry array is not reset; validity is tracked only by r_count, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_entry;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: non-blocking assignments, so each register is updated from the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

  // Newest-match search: scan oldest to newest so the last hit wins.
  // NOTE: every output gets a default before the loop, so no path can infer a latch.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == i_search_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_mem[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/veda_sched.sv
// veda_sched: packs at most one buffered write and one read per cycle into a
// registered command for the 32x32 veda memory, never with addr_a == addr_b,
// and returns read data in order three cycles after acceptance.
// Optional feature macro: VEDA_SCHED_FWD_EN (forward reads from the write
// buffer; when undefined, reads that match a buffered write stall instead).
module veda_sched
  import veda_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  veda_sched_if.slave bus
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic             w_full;
  logic             w_empty;
  logic             w_hit;
  data_t            w_hit_data;
  wentry_t          w_head;
  wentry_t          w_wr_entry;
  logic [CNT_W-1:0] w_count;
  logic             w_wr_ready;
  logic             w_rd_ready;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_fwd;
  logic             w_rd_mem;
  logic             w_pop;
  issue_e           w_issue;

  logic             w_mode;
  logic             w_we;
  addr_t            w_addr_a;
  addr_t            w_addr_b;
  data_t            w_data_in;

  logic             r_mode;
  logic             r_we;
  addr_t            r_addr_a;
  addr_t            r_addr_b;
  data_t            r_data_in;
  rsp_stage_t       r_p0;
  rsp_stage_t       r_p1;
  logic             r_rsp_valid;
  data_t            r_rsp_data;

  assign w_wr_ready = !rst && !w_full;
`ifdef VEDA_SCHED_FWD_EN
  assign w_rd_ready = !rst;
  assign w_fwd      = w_rd_acc && w_hit;
`else
  assign w_rd_ready = !rst && !w_hit;
  assign w_fwd      = 1'b0;
`endif

  assign w_wr_acc   = bus.wr_valid && w_wr_ready;
  assign w_rd_acc   = bus.rd_valid && w_rd_ready;
  assign w_rd_mem   = w_rd_acc && !w_fwd;
  assign w_pop      = !w_empty;
  assign w_issue    = issue_e'({w_pop, w_rd_mem});
  assign w_wr_entry = '{addr: bus.wr_addr, data: bus.wr_data};

  // The search sees only entries present at the start of the cycle, so a
  // write accepted alongside a read is ordered after that read.
  veda_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_wr_acc),
    .i_entry       (w_wr_entry),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_count       (w_count),
    .i_search_addr (bus.rd_addr),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

  // Next memory command; the unused port always points at the inverted
  // address so the two addresses can never collide.
  always_comb begin
    w_mode    = MODE_SCRIBBLE;
    w_we      = 1'b0;
    w_addr_a  = r_addr_a;
    w_addr_b  = r_addr_b;
    w_data_in = r_data_in;
    unique case (w_issue)
      ISSUE_BOTH: begin
        w_mode    = MODE_INTERPRET;
        w_we      = 1'b1;
        w_addr_a  = w_head.addr;
        w_addr_b  = bus.rd_addr;
        w_data_in = w_head.data;
      end
      ISSUE_WRITE: begin
        w_we      = 1'b1;
        w_addr_a  = w_head.addr;
        w_addr_b  = ~w_head.addr;
        w_data_in = w_head.data;
      end
      ISSUE_READ: begin
        w_mode    = MODE_INTERPRET;
        w_addr_a  = ~bus.rd_addr;
        w_addr_b  = bus.rd_addr;
      end
      ISSUE_IDLE: ;
    endcase
  end

  // Registered memory command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= MODE_SCRIBBLE;
      r_we      <= 1'b0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_data_in <= '0;
    end else begin
      r_mode    <= w_mode;
      r_we      <= w_we;
      r_addr_a  <= w_addr_a;
      r_addr_b  <= w_addr_b;
      r_data_in <= w_data_in;
    end
  end

  // Response pipeline: accept -> memory sample -> response register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0        <= '0;
      r_p1        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_p0        <= '{valid: w_rd_acc, fwd: w_fwd, data: (w_fwd ? w_hit_data : '0)};
      r_p1        <= r_p0;
      r_rsp_valid <= r_p1.valid;
      if (r_p1.valid) r_rsp_data <= r_p1.fwd ? r_p1.data : bus.mem_data_out;
    end
  end

  assign bus.wr_ready    = w_wr_ready;
  assign bus.rd_ready    = w_rd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.wbuf_count  = w_count;
  assign bus.mem_mode    = r_mode;
  assign bus.mem_we      = r_we;
  assign bus.mem_addr_a  = r_addr_a;
  assign bus.mem_addr_b  = r_addr_b;
  assign bus.mem_data_in = r_data_in;

endmodule

// File: tb/tb_veda_sched.sv
// tb_veda_sched: directed and randomized checks of veda_sched against a
// program-order memory model, with a behavioural 32x32 veda memory attached.
module tb_veda_sched;
  import veda_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] at_edge;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  veda_sched_if #(.WBUF_DEPTH(DEPTH)) bus ();

  veda_sched #(.WBUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural veda memory: samples the command each edge, registered
  // data_out, equal addresses are a no-op. It is reset alongside the scheduler.
  logic [31:0] tmem [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tmem[i] <= '0;
      bus.mem_data_out <= '0;
    end else if (bus.mem_addr_a != bus.mem_addr_b) begin
      if (bus.mem_we) tmem[bus.mem_addr_a] <= bus.mem_data_in;
      bus.mem_data_out <= tmem[bus.mem_addr_b];
    end
  end

  // Reference model: memory contents in request order, outstanding writes.
  logic [31:0] lmem [32];
  logic [4:0]  mq [$];
  rsp_t        exp_q [$];
  rsp_t        obs_q [$];
  int          edge_n    = 0;
  int          ready_err = 0;
  int          count_err = 0;
  int          cmd_err   = 0;
  int          checks    = 0;
  int          passes    = 0;

  // One clock cycle: drive requests, predict, advance, record outputs.
  task automatic step(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                      input bit rv, input logic [4:0] ra,
                      output bit w_acc, output bit r_acc);
    bit exp_wr;
    bit exp_rd;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    #1;
    exp_wr = !rst && (mq.size() < DEPTH);
    exp_rd = !rst;
`ifndef VEDA_SCHED_FWD_EN
    foreach (mq[i]) if (mq[i] == ra) exp_rd = 1'b0;
`endif
    if (bus.wr_ready !== exp_wr || bus.rd_ready !== exp_rd) ready_err++;
    w_acc = wv && (bus.wr_ready === 1'b1);
    r_acc = rv && (bus.rd_ready === 1'b1);
    if (!rst) begin
      if (r_acc) exp_q.push_back('{data: lmem[ra], at_edge: 32'(edge_n + 2)});
      if (mq.size() > 0) mq.delete(0);
      if (w_acc) begin
        lmem[wa] = wd;
        mq.push_back(wa);
      end
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (bus.rsp_valid === 1'b1) obs_q.push_back('{data: bus.rsp_data, at_edge: 32'(edge_n - 1)});
    if (!rst && int'(bus.wbuf_count) != mq.size()) count_err++;
    if ((bus.mem_we || bus.mem_mode) && bus.mem_addr_a == bus.mem_addr_b) cmd_err++;
  endtask

  task automatic idle(input int n);
    bit wa, ra;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, wa, ra);
  endtask

  // Read that retries while stalled; returns whether it was accepted.
  task automatic read_addr(input logic [4:0] a, output bit ok);
    bit wa, ra;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step(1'b0, 5'd0, 32'd0, 1'b1, a, wa, ra);
      ok = ra;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.rsp_data, bus.wbuf_count,
         bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in} !== '0)
      $display("FAIL reset_outputs: got we=%b mode=%b cnt=%0d rdy=%b%b want all 0",
               bus.mem_we, bus.mem_mode, bus.wbuf_count, bus.wr_ready, bus.rd_ready);
    else passes++;
    rst = 1'b0;
    bus.rd_addr = 5'd0;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b%b want 11", bus.wr_ready, bus.rd_ready);
    else passes++;
  endtask

  task automatic test_write_then_read;
    bit wa, ra, ok;
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, wa, ra);
    checks++;
    if (bus.wbuf_count !== 3'd1) $display("FAIL wtr_count: got %0d want 1", bus.wbuf_count);
    else passes++;
    idle(1);
    checks++;
    if ({bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in} !==
        {1'b0, 1'b1, 5'd3, 5'd28, 32'h11})
      $display("FAIL wtr_cmd: got m%b we%b a%0d b%0d d%h want m0 we1 a3 b28 d11",
               bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in);
    else passes++;
    idle(1);
    read_addr(5'd3, ok);
    idle(5);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].data !== 32'h11)
      $display("FAIL wtr_rsp: got n=%0d %h want n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : rsp_t'(0), exp_q[0]);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_forward;
    bit wa, ra, ok;
    step(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, wa, ra);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, wa, ra);
    checks++;
`ifdef VEDA_SCHED_FWD_EN
    if (ra !== 1'b1) $display("FAIL fwd_accept: got %b want 1", ra);
    else passes++;
`else
    if (ra !== 1'b0) $display("FAIL fwd_stall: got accept=%b want 0", ra);
    else passes++;
`endif
    checks++;
    if ({bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b} !== {1'b0, 1'b1, 5'd5, 5'd26})
      $display("FAIL fwd_cmd: got m%b we%b a%0d b%0d want m0 we1 a5 b26",
               bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b);
    else passes++;
`ifndef VEDA_SCHED_FWD_EN
    read_addr(5'd5, ok);
    checks++;
    if (!ok) $display("FAIL fwd_retry: got accept=0 want 1");
    else passes++;
`endif
    idle(5);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].data !== 32'hAA)
      $display("FAIL fwd_rsp: got n=%0d %h want n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : rsp_t'(0), exp_q[0]);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_pack;
    bit wa, ra;
    step(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, wa, ra);
    idle(3);
    step(1'b1, 5'd1, 32'h01, 1'b0, 5'd0, wa, ra);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, wa, ra);
    checks++;
    if ({ra, bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in} !==
        {1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 32'h01})
      $display("FAIL pack_cmd: got acc%b m%b we%b a%0d b%0d d%h want acc1 m1 we1 a1 b2 d01",
               ra, bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in);
    else passes++;
    idle(5);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].data !== 32'h22)
      $display("FAIL pack_rsp: got n=%0d %h want n=1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : rsp_t'(0), exp_q[0]);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_newest;
    bit wa, ra, ok;
    step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, wa, ra);
    step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, wa, ra);
    read_addr(5'd7, ok);
    idle(5);
    checks++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].data !== 32'h2)
      $display("FAIL newest_rsp: got acc=%b n=%0d %h want n=1 data 2", ok, obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : rsp_t'(0));
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    bit wa, ra, ok;
    int lost = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0, wa, ra);
      if (!wa) lost++;
    end
    checks++;
    if (lost != 0) $display("FAIL b2b_accept: got %0d refused want 0", lost);
    else passes++;
    idle(2);
    for (int i = 0; i < 5; i++) read_addr(5'(10 + i), ok);
    idle(5);
    checks++;
    if (obs_q.size() != 5) $display("FAIL b2b_rsp_count: got %0d want 5", obs_q.size());
    else passes++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== 32'h100 + 32'(i) || obs_q[i] !== exp_q[i])
        $display("FAIL b2b_rsp[%0d]: got %h want data %h", i, obs_q[i], 32'h100 + 32'(i));
      else passes++;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random;
    bit wa, ra;
    rsp_t got;
    for (int c = 0; c < 400; c++)
      step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), wa, ra);
    idle(5);
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL rand_rsp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passes++;
    foreach (exp_q[i]) begin
      got = '0;
      if (i < obs_q.size()) got = obs_q[i];
      checks++;
      if (got !== exp_q[i]) $display("FAIL rand_rsp[%0d]: got %h want %h", i, got, exp_q[i]);
      else passes++;
    end
    checks++;
    if (ready_err != 0) $display("FAIL ready_cycles: got %0d wrong want 0", ready_err);
    else passes++;
    checks++;
    if (count_err != 0) $display("FAIL wbuf_count_cycles: got %0d wrong want 0", count_err);
    else passes++;
    checks++;
    if (cmd_err != 0) $display("FAIL addr_collision: got %0d want 0", cmd_err);
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midflight;
    bit wa, ra, ok;
    step(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd0, wa, ra);
    idle(3);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, wa, ra);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, wa, ra);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.wr_ready, bus.rd_ready, bus.rsp_valid, bus.rsp_data, bus.wbuf_count,
         bus.mem_mode, bus.mem_we, bus.mem_addr_a, bus.mem_addr_b, bus.mem_data_in} !== '0)
      $display("FAIL midrst_outputs: got we=%b rsp=%b cnt=%0d want all 0",
               bus.mem_we, bus.rsp_valid, bus.wbuf_count);
    else passes++;
    mq.delete();
    exp_q.delete();
    obs_q.delete();
    foreach (lmem[i]) lmem[i] = '0;
    idle(2);
    rst = 1'b0;
    idle(4);
    checks++;
    if (obs_q.size() != 0) $display("FAIL midrst_no_rsp: got %0d responses want 0", obs_q.size());
    else passes++;
    read_addr(5'd20, ok);
    read_addr(5'd3, ok);
    idle(5);
    checks++;
    if (obs_q.size() != 2 || obs_q[0].data !== 32'h0 || obs_q[1].data !== 32'h0 ||
        obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1])
      $display("FAIL midrst_rsp: got n=%0d %h want n=2 data 0", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : rsp_t'(0));
    else passes++;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    foreach (lmem[i]) lmem[i] = '0;
    test_reset();
    test_write_then_read();
    test_forward();
    test_pack();
    test_newest();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
